// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_responder
//  Purpose  : Responder side of the core's data-memory port. It serves loads
//             and stores from an internal word array through a valid/ready
//             request/response handshake, inserting WAIT_CYCLES wait states,
//             and flags misaligned, out-of-range and malformed commands.
//  Revision : 1.0  initial release
// ============================================================================
module data_mem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic [7:0]  err_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          rd_q;
  logic          err_q;

  logic [31:0]   mem [DEPTH];

  logic          req_fire;
  logic          req_err;
  logic          access;
  logic [AW-1:0] acc_idx;
  logic [31:0]   acc_wdata;
  logic          acc_rd;
  logic          acc_err;

  // Requests are only taken in IDLE and never while reset is held.
  assign req_ready = (state == ST_IDLE) && !rst;
  assign busy      = (state != ST_IDLE);
  assign req_fire  = req_valid && req_ready;

  // A request is rejected when the command is ambiguous, the address is not
  // word aligned, or the word index falls outside the array.
  assign req_err = (req_rd == req_wr) ||
                   (req_addr[1:0] != 2'b00) ||
                   (req_addr[31:2] >= 30'(DEPTH));

  // The access edge is the one that enters RESP. With zero wait states it is
  // the handshake edge itself, so the live request fields are used then;
  // otherwise the values latched at the handshake are used.
  assign access    = !rst &&
                     ((req_fire && (WAIT_CYCLES == 0)) ||
                      ((state == ST_WAIT) && (cnt == 4'd1)));
  assign acc_idx   = (state == ST_IDLE) ? req_addr[AW+1:2] : idx_q;
  assign acc_wdata = (state == ST_IDLE) ? req_wdata        : wdata_q;
  assign acc_rd    = (state == ST_IDLE) ? req_rd           : rd_q;
  assign acc_err   = (state == ST_IDLE) ? req_err          : err_q;

  // Array write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (access && !acc_err && !acc_rd) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  // Request/response state machine with registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      idx_q      <= '0;
      wdata_q    <= 32'd0;
      rd_q       <= 1'b0;
      err_q      <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      err_count  <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_fire) begin
            idx_q   <= req_addr[AW+1:2];
            wdata_q <= req_wdata;
            rd_q    <= req_rd;
            err_q   <= req_err;
            if (WAIT_CYCLES == 0) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
            end else begin
              state <= ST_WAIT;
              cnt   <= 4'(WAIT_CYCLES);
            end
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          resp_valid <= 1'b0;
        end
      endcase

      if (access) begin
        resp_rdata <= (!acc_err && acc_rd) ? mem[acc_idx] : 32'd0;
        resp_err   <= acc_err;
        if (acc_err && (err_count != 8'hFF)) begin
          err_count <= err_count + 8'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_responder
//  Purpose  : Directed bench for data_mem_responder: a vector table of single
//             transactions plus hand sequences for back-pressure, reset in the
//             wait window, zero wait states and error counter saturation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_mem_responder;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_rd, req_wr, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;
  logic [7:0]  err_count;

  logic        req_valid1, req_rd1, req_wr1, resp_ready1;
  logic [31:0] req_addr1, req_wdata1;
  logic        req_ready1, resp_valid1, resp_err1, busy1;
  logic [31:0] resp_rdata1;
  logic [7:0]  err_count1;

  int checks   = 0;
  int failures = 0;
  int exp_ec   = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy), .err_count(err_count)
  );

  data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1),
    .req_rd(req_rd1), .req_wr(req_wr1),
    .req_addr(req_addr1), .req_wdata(req_wdata1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1),
    .resp_rdata(resp_rdata1), .resp_err(resp_err1),
    .busy(busy1), .err_count(err_count1)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One full transaction on the WAIT_CYCLES=2 instance.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic exp_err,
                        input logic [31:0] exp_rdata);
    int n;
    int lat;
    @(negedge clk);
    req_valid = 1'b1; req_rd = rd; req_wr = wr; req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_before", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    // Scramble the request after the handshake; it must be ignored.
    req_valid = 1'b0; req_addr = ~addr; req_wdata = ~wdata; req_rd = ~rd; req_wr = ~wr;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 1 + W);
    chk("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
    chk("resp_rdata", resp_rdata, exp_rdata);
    chk("busy_resp", {31'd0, busy}, 32'd1);
    if (exp_err && exp_ec < 255) exp_ec++;
    chk("err_count", {24'd0, err_count}, exp_ec);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("req_ready_after", {31'd0, req_ready}, 32'd1);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("resp_valid_idle", {31'd0, resp_valid}, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"},  {31'd0, req_ready},  32'd1);
    chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata,          32'd0);
    chk({tag, "_resp_err"},   {31'd0, resp_err},   32'd0);
    chk({tag, "_busy"},       {31'd0, busy},       32'd0);
    chk({tag, "_err_count"},  {24'd0, err_count},  32'd0);
  endtask

  // Store 0x20=0xFFFFFFFF, then reset `delay` cycles into the wait window.
  task automatic rst_in_wait(input int delay);
    int seen;
    @(negedge clk);
    req_valid = 1'b1; req_rd = 1'b0; req_wr = 1'b1;
    req_addr = 32'h20; req_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (delay) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("req_ready_in_rst", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_ec = 0;
    #1;
    chk_reset_outputs("post_rst");
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    chk("dropped_resp", seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int hold_bad;
    vecs[0]  = '{1'b0, 1'b1, 32'h10,  32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h10,  32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 1'b0, 32'h12,  32'h0,         1'b1, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'h100, 32'h0,         1'b1, 32'h0};
    vecs[4]  = '{1'b1, 1'b1, 32'h10,  32'h0,         1'b1, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 32'h10,  32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[6]  = '{1'b0, 1'b1, 32'hFC,  32'hCAFE_F00D, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 32'hFC,  32'h0,         1'b0, 32'hCAFE_F00D};
    vecs[8]  = '{1'b0, 1'b1, 32'h00,  32'h0BAD_C0DE, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 1'b1, 32'h100, 32'h1111_1111, 1'b1, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 32'h00,  32'h0,         1'b0, 32'h0BAD_C0DE};
    vecs[11] = '{1'b0, 1'b0, 32'h04,  32'h0,         1'b1, 32'h0};
    vecs[12] = '{1'b0, 1'b1, 32'h02,  32'h2222_2222, 1'b1, 32'h0};
    vecs[13] = '{1'b1, 1'b0, 32'h00,  32'h0,         1'b0, 32'h0BAD_C0DE};

    rst = 1'b1;
    req_valid = 1'b0; req_rd = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0;
    req_valid1 = 1'b0; req_rd1 = 1'b0; req_wr1 = 1'b0; req_addr1 = '0; req_wdata1 = '0;
    resp_ready1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("req_ready_during_rst", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset");

    // Vector table
    for (int i = 0; i < 14; i++) begin
      do_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].err, vecs[i].rdata);
    end

    // Back-pressure: hold resp_ready low for 5 cycles in RESP
    do_req(1'b0, 1'b1, 32'h20, 32'h1234_5678, 1'b0, 32'h0);
    @(negedge clk);
    req_valid = 1'b1; req_rd = 1'b1; req_wr = 1'b0; req_addr = 32'h20;
    @(negedge clk);
    req_addr = 32'h10;   // stays valid but must not be accepted
    repeat (W) @(negedge clk);
    hold_bad = 0;
    repeat (5) begin
      if (!resp_valid || resp_rdata !== 32'h1234_5678 || resp_err || req_ready || !busy)
        hold_bad++;
      @(negedge clk);
    end
    chk("hold_stable", hold_bad, 0);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("hold_release_req_ready", {31'd0, req_ready}, 32'd1);
    chk("hold_release_valid", {31'd0, resp_valid}, 32'd0);

    // Reset in the first wait cycle, then on the access edge itself
    rst_in_wait(0);
    do_req(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h1234_5678);
    rst_in_wait(1);
    do_req(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h1234_5678);

    // Zero wait states on the second instance
    @(negedge clk);
    req_valid1 = 1'b1; req_rd1 = 1'b0; req_wr1 = 1'b1; req_addr1 = 32'h04; req_wdata1 = 32'h55;
    @(negedge clk);
    req_valid1 = 1'b0;
    chk("w0_store_valid", {31'd0, resp_valid1}, 32'd1);
    chk("w0_store_err", {31'd0, resp_err1}, 32'd0);
    chk("w0_store_rdata", resp_rdata1, 32'd0);
    resp_ready1 = 1'b1;
    @(negedge clk);
    resp_ready1 = 1'b0;
    chk("w0_ready", {31'd0, req_ready1}, 32'd1);
    req_valid1 = 1'b1; req_rd1 = 1'b1; req_wr1 = 1'b0; req_addr1 = 32'h04; req_wdata1 = 32'h0;
    @(negedge clk);
    req_valid1 = 1'b0;
    chk("w0_load_valid", {31'd0, resp_valid1}, 32'd1);
    chk("w0_load_rdata", resp_rdata1, 32'h55);
    resp_ready1 = 1'b1;
    @(negedge clk);
    resp_ready1 = 1'b0;

    // Saturation of the error counter
    for (int i = 0; i < 300; i++) begin
      do_req(1'b1, 1'b0, 32'h01 + 32'(i % 3), 32'h0, 1'b1, 32'h0);
    end
    chk("err_count_saturated", {24'd0, err_count}, 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
# data_mem_responder

Responder end of the datapath's data-memory interface. The single-cycle core issues loads and stores with read-enable, write-enable, byte address and write data. This block serves those accesses from an internal word array through a valid/ready request/response handshake, with a configurable number of wait states. It also reports alignment, range and command errors, so the core can later be stalled on a memory that is not zero-latency.

## Interface
Parameters:
- DEPTH, 64, number of 32-bit words in the array (power of two, 4..1024)
- WAIT_CYCLES, 2, wait states between request acceptance and response (0..15)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request this cycle
- req_rd  in  1  load command (core's memread)
- req_wr  in  1  store command (core's memwrite)
- req_addr  in  32  byte address (ALU result)
- req_wdata  in  32  store data (rt register value)
- resp_valid  out  1  response present
- resp_ready  in  1  core consumes response
- resp_rdata  out  32  load data; 0 for stores and errors
- resp_err  out  1  request was rejected; no array access occurred
- busy  out  1  a request is in flight (state other than IDLE)
- err_count  out  8  saturating count of error responses

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Handshake when req_valid&&req_ready. On handshake, latch addr, wdata and command, and evaluate the error condition.
  - Error when req_rd==req_wr (both or neither set), or req_addr[1:0]!=0, or req_addr[31:2]>=DEPTH.
  - On handshake: if WAIT_CYCLES==0, go to RESP; else go to WAIT with cnt=WAIT_CYCLES.
- WAIT:
  - cnt decrements each cycle.
  - When cnt==1, the next edge enters RESP.
- Access edge: the edge that enters RESP.
  - Store without error: array[addr[31:2]] <= wdata.
  - Load without error: resp_rdata <= array[addr[31:2]].
  - Error or store: resp_rdata <= 0.
  - resp_err registered on the same edge.
- RESP:
  - resp_valid=1. resp_rdata and resp_err are held stable until the handshake.
  - On resp_valid&&resp_ready: go to IDLE.
  - resp_valid and resp_rdata/resp_err hold while resp_ready=0.
- err_count increments by 1 on the access edge of each error; it saturates at 255 and never wraps.
- Array contents are not cleared by reset. Array contents are undefined until written.

## Timing
- Reset values: state IDLE, req_ready=1 from the first cycle after rst deasserts, resp_valid=0, resp_rdata=0, resp_err=0, busy=0, err_count=0, cnt=0.
- During rst=1, req_ready=0. No handshake is taken while rst=1.
- Latency: for a handshake in cycle t, resp_valid is first high in cycle t+1+WAIT_CYCLES.
- A store is visible to any request accepted after its response handshake.
- Throughput: one request per WAIT_CYCLES+2 cycles at best. No new request is accepted in the cycle resp_ready consumes a response; req_ready rises the following cycle.
- busy=1 in WAIT and RESP. busy equals !req_ready when not in reset.
- Request inputs are ignored outside IDLE. Changes to them after the handshake have no effect.
- Reset mid-operation:
  - rst in WAIT before the access edge: the pending store is not committed and the response is dropped.
  - rst on the access edge itself: reset wins and there is no write.
- Simultaneous events:
  - resp_ready high outside RESP has no effect.
  - req_valid high in RESP is not accepted.

## Test plan
- WAIT_CYCLES=2, store addr 0x10 data 0xDEADBEEF, then load 0x10 -> the store's resp_valid is high exactly 3 cycles after its handshake with resp_err=0 and resp_rdata=0. The load then returns 0xDEADBEEF with resp_err=0.
- Load 0x12 (misaligned), then load 0x100 with DEPTH=64 (out of range), then req_rd=req_wr=1 -> each response has resp_err=1 and resp_rdata=0, and err_count ends at 3. A follow-up load of 0x10 still returns 0xDEADBEEF.
- Hold resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_rdata and resp_err are stable, and req_ready stays 0. After resp_ready=1, the FSM returns to IDLE and req_ready=1 on the next cycle.
- Store 0x20=0x12345678, then a store to 0x20 of 0xFFFFFFFF with rst pulsed in the first WAIT cycle -> no response, and all outputs are at reset values. A subsequent load of 0x20 returns 0x12345678.
- WAIT_CYCLES=0: load from 0x04 after storing 0x00000055 -> resp_valid is high in the cycle after the handshake with data 0x00000055.
- Issue 300 misaligned requests -> err_count holds at 255 without wrapping.
